// File: rtl/spike_encode_scheduler.sv
// ---------------------------------------------------------------------------
// spike_encode_scheduler
//   Shares one Poisson spike encoder across NUM_CH channels. For each timestep
//   it reads every channel's rate from a synchronous-read rate memory and feeds
//   it to the encoder, one channel per cycle. The returned spike bits are
//   collected into an NUM_CH-bit vector, which is then offered downstream with
//   a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, num_steps    run request; num_steps is latched when start is accepted
//   abort               terminates the run from any state (highest priority)
//   busy, done          run in progress / one-cycle normal-completion pulse
//   rate_addr/rate_data rate memory read port (data arrives one cycle later)
//   enc_en/enc_rate     encoder drive; enc_rate passes rate_data straight through
//   enc_spike           encoder result, valid the cycle after enc_en
//   spk_valid/ready     output handshake
//   spk_vec/spk_step    spike vector and the timestep it belongs to
// ---------------------------------------------------------------------------
module spike_encode_scheduler #(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RATE_WIDTH = 8,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [STEP_WIDTH-1:0] num_steps,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rate_addr,
  input  logic [RATE_WIDTH-1:0] rate_data,
  output logic                  enc_en,
  output logic [RATE_WIDTH-1:0] enc_rate,
  input  logic                  enc_spike,
  output logic                  spk_valid,
  input  logic                  spk_ready,
  output logic [NUM_CH-1:0]     spk_vec,
  output logic [STEP_WIDTH-1:0] spk_step
);

  // Scan cycle counter spans 0 .. NUM_CH+1 (issue, memory latency, encoder latency).
  localparam int unsigned CW = $clog2(NUM_CH + 2);
  localparam logic [CW-1:0] LAST_ISSUE = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] LAST_SCAN  = CW'(NUM_CH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [STEP_WIDTH-1:0]   step_q;
  logic [STEP_WIDTH-1:0]   num_q;
  logic [NUM_CH-1:0]       vec_q;
  logic [ADDR_WIDTH-1:0]   rate_addr_q;
  logic                    enc_en_q;
  logic                    spk_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    last_step_d;

  // Compare against num_q-1 so that a run of all-ones steps never needs step_q to wrap.
  always_comb begin
    last_step_d = 1'b0;
    last_step_d = (step_q == (num_q - STEP_WIDTH'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_q      <= '0;
      num_q       <= '0;
      vec_q       <= '0;
      rate_addr_q <= '0;
      enc_en_q    <= 1'b0;
      spk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        vec_q       <= '0;
        enc_en_q    <= 1'b0;
        spk_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (num_steps != '0) begin
                num_q       <= num_steps;
                step_q      <= '0;
                cnt_q       <= '0;
                rate_addr_q <= '0;
                vec_q       <= '0;
                busy_q      <= 1'b1;
                state_q     <= S_SCAN;
              end else begin
                done_q <= 1'b1;
              end
            end
          end

          S_SCAN: begin
            // cnt_q = k: address k is on the bus (k < NUM_CH), the encoder sees
            // channel k-1, and the spike for channel k-2 is arriving.
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q < LAST_ISSUE) begin
              rate_addr_q <= ADDR_WIDTH'(cnt_q + CW'(1));
            end
            enc_en_q <= (cnt_q <= LAST_ISSUE);
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              if (cnt_q == CW'(c + 2)) begin
                vec_q[c] <= enc_spike;
              end
            end
            if (cnt_q == LAST_SCAN) begin
              cnt_q       <= '0;
              spk_valid_q <= 1'b1;
              state_q     <= S_EMIT;
            end
          end

          S_EMIT: begin
            if (spk_ready) begin
              spk_valid_q <= 1'b0;
              if (last_step_d) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                step_q      <= step_q + STEP_WIDTH'(1);
                cnt_q       <= '0;
                rate_addr_q <= '0;
                vec_q       <= '0;
                state_q     <= S_SCAN;
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rate_addr = rate_addr_q;
  assign enc_en    = enc_en_q;
  assign enc_rate  = rate_data;
  assign spk_valid = spk_valid_q;
  assign spk_vec   = vec_q;
  assign spk_step  = step_q;

endmodule

// File: doc/spike_encode_scheduler.md
Name: spike_encode_scheduler

Overview:
Time-multiplexes one shared Poisson spike encoder (LFSR comparator, registered spike output, `en`-gated) across NUM_CH input channels for a programmed number of timesteps. Per timestep it fetches each channel's rate from a synchronous-read rate memory, drives the encoder, and collects the returned spike bits into a NUM_CH-bit vector. It then emits the vector downstream with a valid/ready handshake. It sits between the rate buffer and the crossbar input driver.

Parameters:
NUM_CH, 16, number of input channels (≥2)
ADDR_WIDTH, 4, rate memory address width; 2**ADDR_WIDTH ≥ NUM_CH
RATE_WIDTH, 8, rate word width; matches encoder rate port
STEP_WIDTH, 16, timestep counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request
num_steps  in  STEP_WIDTH  timesteps to run; sampled on accepted start
abort  in  1  terminate run
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on normal completion
rate_addr  out  ADDR_WIDTH  rate memory read address (data returns next cycle)
rate_data  in  RATE_WIDTH  rate memory read data
enc_en  out  1  encoder enable
enc_rate  out  RATE_WIDTH  encoder rate; combinational pass of rate_data
enc_spike  in  1  encoder spike; valid the cycle after enc_en
spk_valid  out  1  spike vector valid
spk_ready  in  1  downstream accept
spk_vec  out  NUM_CH  bit c = channel c spike for this step
spk_step  out  STEP_WIDTH  timestep index of spk_vec

Behaviour:
- Async reset: state IDLE. All outputs 0. Counters and vector cleared.
- States: IDLE, SCAN, EMIT.
- IDLE:
  - start=1, num_steps≠0: latch num_steps, step=0, ch=0, go SCAN next cycle, busy=1.
  - start=1, num_steps=0: done pulses next cycle, stay IDLE.
- SCAN is a 3-stage pipeline with one channel per cycle:
  - Stage A: rate_addr=ch, ch increments each cycle through 0..NUM_CH-1.
  - Stage B, one cycle later: enc_en=1, enc_rate=rate_data.
  - Stage C, one cycle after B: enc_spike written to vec[channel of that issue].
  - SCAN lasts NUM_CH+2 cycles. enc_en is high for exactly NUM_CH consecutive cycles per step. vec is cleared on SCAN entry.
- EMIT: spk_valid=1, spk_vec=vec, spk_step=step.
  - valid, vec and step are held stable until spk_ready=1. Valid never drops without a handshake except on abort.
  - enc_en=0 throughout EMIT, so the encoder LFSR does not advance and backpressure does not change the spike sequence.
- On handshake (spk_valid & spk_ready):
  - If step+1==num_steps: done pulses, go IDLE, busy drops in the same cycle as done.
  - Otherwise: step++, go SCAN.
- spk_valid first rises NUM_CH+3 cycles after the cycle in which start is sampled.
- start while busy: ignored; num_steps is not re-sampled.
- abort (any state, priority over start and handshake): IDLE next cycle. enc_en, spk_valid and busy go 0, no done pulse, the partial vector is discarded. Encoder spikes still in flight are dropped.
- abort and start in the same IDLE cycle: start is ignored.
- step counter: compare against latched num_steps. A run of num_steps = 2**STEP_WIDTH-1 completes without wrap.
- rate_addr holds its last value outside SCAN stage A. enc_rate is don't-care when enc_en=0.

Test Plan:
1. NUM_CH=4, all rates 0, num_steps=3, ready tied high → three handshakes with spk_vec=0 and spk_step=0,1,2, then one done pulse, busy=0.
2. NUM_CH=4, num_steps=1, start at cycle 0 → rate_addr 0,1,2,3 on cycles 1–4; enc_en high cycles 2–5 with enc_rate equal to mem[0..3]; spk_valid at cycle 7.
3. Random rates, NUM_CH=16, num_steps=8, encoder RTL plus reference LFSR model (seed 0xACE1, taps 0xB400) → every spk_vec matches the model bit-exactly.
4. Repeat scenario 3 with spk_ready low for 10 cycles at each EMIT → spk_vec/spk_step stable while stalled, enc_en=0 during stalls, vector sequence identical to scenario 3.
5. abort in mid-SCAN of step 2 → busy=0, enc_en=0, spk_valid=0 next cycle, no done. A following start with num_steps=1 restarts at spk_step=0.
6. start with num_steps=0 → done one cycle later and no spk_valid. Then start during a run with num_steps=5 → ignored, and the original step count completes.
